// File: rtl/wave_gen_pkg.sv
// Shared waveform-generator definitions: waveform encodings and reset constants.
package wave_gen_pkg;

  // Waveform selector encoding; codes 5..7 are reserved and produce a zero output.
  typedef enum logic [2:0] {
    FN_SAW   = 3'd0,
    FN_RSAW  = 3'd1,
    FN_TRI   = 3'd2,
    FN_SQR   = 3'd3,
    FN_NOISE = 3'd4
  } func_e;

  localparam int unsigned FUNC_W = 3;

  // Power-on waveform selection and period marker state.
  localparam logic [FUNC_W-1:0] RST_FUNC         = FN_SAW;
  localparam logic              RST_PERIOD_START = 1'b0;

endpackage

// File: rtl/wave_gen_multi_divider.sv
// Programmable step-rate divider: one tick every (2^FREQ_W - freq_reg) enabled clocks.
module freq_divider #(
  parameter int unsigned FREQ_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              freq_load,
  input  logic [FREQ_W-1:0] freq_in,
  output logic              tick
);

  logic [FREQ_W-1:0] freq_reg;
  logic [FREQ_W-1:0] div_cnt;
  logic [FREQ_W-1:0] reload;

  assign tick = en & (div_cnt == '1);

  // A load in the same cycle as a tick takes effect immediately.
  assign reload = freq_load ? freq_in : freq_reg;

  // Reload register follows freq_load even while frozen; counter only runs when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_reg <= '1;
      div_cnt  <= '0;
    end else begin
      if (freq_load) begin
        freq_reg <= freq_in;
      end
      if (tick) begin
        div_cnt <= reload;
      end else if (en) begin
        div_cnt <= div_cnt + FREQ_W'(1);
      end
    end
  end

endmodule

// File: rtl/wave_gen_multi.sv
// Multi-waveform function generator: phase accumulator, LFSR noise source and
// waveform mux, with mode/duty changes deferred to waveform period boundaries.
module wave_gen_multi
  import wave_gen_pkg::*;
#(
  parameter int unsigned      OUT_W     = 8,
  parameter int unsigned      FREQ_W    = 5,
  parameter logic [OUT_W-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              freq_load,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic [2:0]        func,
  input  logic [OUT_W-1:0]  duty,
  output logic [OUT_W-1:0]  out,
  output logic              period_start
);

  logic             tick;
  logic [OUT_W:0]   ph;
  logic [OUT_W:0]   ph_next;
  logic [OUT_W-1:0] lfsr;
  logic [OUT_W-1:0] lfsr_next;
  logic [2:0]       act_func;
  logic [OUT_W-1:0] act_duty;
  logic             bnd;
  logic [2:0]       sel_func;
  logic [OUT_W-1:0] sel_duty;
  logic [OUT_W-1:0] s;
  logic [OUT_W-1:0] sample;

  freq_divider #(
    .FREQ_W (FREQ_W)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .freq_load (freq_load),
    .freq_in   (freq_in),
    .tick      (tick)
  );

  assign ph_next   = ph + (OUT_W + 1)'(1);
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  assign s         = ph_next[OUT_W-1:0];

  // Triangle spans the full phase range; every other mode repeats on the low bits.
  always_comb begin
    bnd = 1'b0;
    if (tick) begin
      if (act_func == FN_TRI) begin
        bnd = (ph_next == '0);
      end else begin
        bnd = (s == '0);
      end
    end
  end

  // The first sample of a new period already uses the newly requested mode/duty.
  assign sel_func = bnd ? func : act_func;
  assign sel_duty = bnd ? duty : act_duty;

  // Waveform mux evaluated on the post-increment phase and post-advance LFSR.
  always_comb begin
    sample = '0;
    case (sel_func)
      FN_SAW:   sample = s;
      FN_RSAW:  sample = ~s;
      FN_TRI:   sample = ph_next[OUT_W] ? ~s : s;
      FN_SQR:   sample = (s < sel_duty) ? '1 : '0;
      FN_NOISE: sample = lfsr_next;
      default:  sample = '0;
    endcase
  end

  // Phase, noise and output advance on tick; selection tracks inputs freely while frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph           <= '0;
      lfsr         <= OUT_W'(1);
      act_func     <= RST_FUNC;
      act_duty     <= '0;
      out          <= '0;
      period_start <= RST_PERIOD_START;
    end else begin
      if (tick) begin
        ph   <= ph_next;
        lfsr <= lfsr_next;
        out  <= sample;
      end
      if (!en) begin
        act_func <= func;
        act_duty <= duty;
      end else if (bnd) begin
        act_func <= sel_func;
        act_duty <= sel_duty;
      end
      // bnd already implies en, so the marker is held low while frozen.
      period_start <= bnd;
    end
  end

endmodule

// File: tb/tb_wave_gen_multi.sv
// Directed self-checking bench for wave_gen_multi (OUT_W=8, FREQ_W=5).
module tb_wave_gen_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       freq_load = 1'b0;
  logic [4:0] freq_in = 5'd0;
  logic [2:0] func = 3'd0;
  logic [7:0] duty = 8'd0;
  logic [7:0] out;
  logic       period_start;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] noise_tbl [8] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8, 8'h64};

  wave_gen_multi #(
    .OUT_W     (8),
    .FREQ_W    (5),
    .LFSR_TAPS (8'hB8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .freq_load    (freq_load),
    .freq_in      (freq_in),
    .func         (func),
    .duty         (duty),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic en_v, input logic [2:0] f, input logic [7:0] d);
    en        = en_v;
    func      = f;
    duty      = d;
    freq_load = 1'b0;
    freq_in   = 5'd31;
    reset     = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    en = 1'b1;
    freq_load = 1'b1;
    freq_in = 5'd31;
    #1;
    vectors++;
    if (out !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_out_t0: got %0h expected 0", out);
    end
    vectors++;
    if (period_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ps_t0: got %0b expected 0", period_start);
    end
    step(3);
    vectors++;
    if (out !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_out_held: got %0h expected 0", out);
    end
    freq_load = 1'b0;
  endtask

  task automatic test_saw;
    logic [7:0] e;
    do_reset(1'b1, 3'd0, 8'd0);
    freq_load = 1'b1;
    freq_in   = 5'd31;
    step(1);
    freq_load = 1'b0;
    step(30);
    vectors++;
    if (out !== 8'd0) begin
      miscompares++;
      $display("FAIL saw_pre_tick: got %0h expected 0", out);
    end
    for (int i = 1; i <= 600; i++) begin
      step(1);
      e = 8'(i);
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("FAIL saw_out[%0d]: got %0h expected %0h", i, out, e);
      end
      vectors++;
      if (period_start !== (e == 8'd0)) begin
        miscompares++;
        $display("FAIL saw_ps[%0d]: got %0b expected %0b", i, period_start, (e == 8'd0));
      end
    end
  endtask

  task automatic test_freq;
    logic [7:0] e;
    do_reset(1'b1, 3'd0, 8'd0);
    step(32);
    vectors++;
    if (out !== 8'd1) begin
      miscompares++;
      $display("FAIL freq_first_tick: got %0h expected 1", out);
    end
    freq_load = 1'b1;
    freq_in   = 5'd30;
    step(1);
    freq_load = 1'b0;
    vectors++;
    if (out !== 8'd2) begin
      miscompares++;
      $display("FAIL freq_load_bypass: got %0h expected 2", out);
    end
    for (int j = 1; j <= 8; j++) begin
      step(1);
      e = 8'(2 + j / 2);
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("FAIL freq_div2[%0d]: got %0h expected %0h", j, out, e);
      end
    end
    freq_load = 1'b1;
    freq_in   = 5'd0;
    step(1);
    freq_load = 1'b0;
    vectors++;
    if (out !== 8'd6) begin
      miscompares++;
      $display("FAIL freq_load0_no_tick: got %0h expected 6", out);
    end
    step(1);
    vectors++;
    if (out !== 8'd7) begin
      miscompares++;
      $display("FAIL freq_load0_tick: got %0h expected 7", out);
    end
    for (int j = 1; j <= 31; j++) begin
      step(1);
      vectors++;
      if (out !== 8'd7) begin
        miscompares++;
        $display("FAIL freq_div32_hold[%0d]: got %0h expected 7", j, out);
      end
    end
    step(1);
    vectors++;
    if (out !== 8'd8) begin
      miscompares++;
      $display("FAIL freq_div32_step: got %0h expected 8", out);
    end
  endtask

  task automatic test_tri_switch;
    logic [7:0] e;
    do_reset(1'b1, 3'd0, 8'd0);
    step(32);
    step(355);
    vectors++;
    if (out !== 8'd100) begin
      miscompares++;
      $display("FAIL tri_pre_switch: got %0h expected 64", out);
    end
    func = 3'd2;
    step(155);
    vectors++;
    if (out !== 8'd255 || period_start !== 1'b0) begin
      miscompares++;
      $display("FAIL tri_saw_end: got %0h/%0b expected ff/0", out, period_start);
    end
    step(1);
    vectors++;
    if (out !== 8'd0 || period_start !== 1'b1) begin
      miscompares++;
      $display("FAIL tri_first: got %0h/%0b expected 0/1", out, period_start);
    end
    for (int k = 1; k <= 511; k++) begin
      step(1);
      e = (k < 256) ? 8'(k) : 8'(511 - k);
      vectors++;
      if (out !== e || period_start !== 1'b0) begin
        miscompares++;
        $display("FAIL tri_out[%0d]: got %0h/%0b expected %0h/0", k, out, period_start, e);
      end
    end
    step(1);
    vectors++;
    if (out !== 8'd0 || period_start !== 1'b1) begin
      miscompares++;
      $display("FAIL tri_period_512: got %0h/%0b expected 0/1", out, period_start);
    end
  endtask

  task automatic test_square;
    logic [7:0] e;
    int         sv;
    int         dv;
    do_reset(1'b0, 3'd3, 8'd64);
    step(1);
    en = 1'b1;
    step(31);
    vectors++;
    if (out !== 8'd0) begin
      miscompares++;
      $display("FAIL sqr_pre_tick: got %0h expected 0", out);
    end
    for (int k = 1; k <= 512; k++) begin
      step(1);
      sv = k % 256;
      dv = (k < 256) ? 64 : 192;
      e  = (sv < dv) ? 8'hFF : 8'h00;
      vectors++;
      if (out !== e || period_start !== (sv == 0)) begin
        miscompares++;
        $display("FAIL sqr_out[%0d]: got %0h/%0b expected %0h/%0b", k, out, period_start, e,
                 (sv == 0));
      end
      if (k == 128) duty = 8'd192;
    end
  endtask

  task automatic test_noise;
    do_reset(1'b0, 3'd4, 8'd0);
    step(1);
    en = 1'b1;
    step(31);
    vectors++;
    if (out !== 8'd0) begin
      miscompares++;
      $display("FAIL noise_pre_tick: got %0h expected 0", out);
    end
    for (int i = 0; i < 8; i++) begin
      step(1);
      vectors++;
      if (out !== noise_tbl[i]) begin
        miscompares++;
        $display("FAIL noise_seq[%0d]: got %0h expected %0h", i, out, noise_tbl[i]);
      end
    end
    for (int i = 9; i <= 256; i++) begin
      step(1);
      vectors++;
      if (out === 8'd0) begin
        miscompares++;
        $display("FAIL noise_zero[%0d]: got 0 expected nonzero", i);
      end
      if (i == 255) begin
        vectors++;
        if (out !== 8'h01) begin
          miscompares++;
          $display("FAIL noise_wrap_255: got %0h expected 1", out);
        end
      end
      if (i == 256) begin
        vectors++;
        if (out !== 8'hB8) begin
          miscompares++;
          $display("FAIL noise_repeat_256: got %0h expected b8", out);
        end
      end
    end
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      vectors++;
      if (out !== 8'hB8 || period_start !== 1'b0) begin
        miscompares++;
        $display("FAIL noise_freeze[%0d]: got %0h/%0b expected b8/0", i, out, period_start);
      end
    end
    en = 1'b1;
    step(1);
    vectors++;
    if (out !== 8'h5C) begin
      miscompares++;
      $display("FAIL noise_resume: got %0h expected 5c", out);
    end
  endtask

  task automatic test_async_reset;
    do_reset(1'b0, 3'd2, 8'd0);
    step(1);
    en = 1'b1;
    step(32);
    step(299);
    vectors++;
    if (out !== 8'd211) begin
      miscompares++;
      $display("FAIL areset_pre_tri: got %0h expected d3", out);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (out !== 8'd0 || period_start !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_immediate: got %0h/%0b expected 0/0", out, period_start);
    end
    step(2);
    reset = 1'b1;
    step(31);
    vectors++;
    if (out !== 8'd0) begin
      miscompares++;
      $display("FAIL areset_pre_tick: got %0h expected 0", out);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1);
      vectors++;
      if (out !== 8'(i)) begin
        miscompares++;
        $display("FAIL areset_restart[%0d]: got %0h expected %0h", i, out, i);
      end
    end
    // Saw period ends at phase 256 and hands over to triangle in its upper half.
    step(253);
    vectors++;
    if (out !== 8'hFF || period_start !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_bnd_256: got %0h/%0b expected ff/1", out, period_start);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (out !== 8'd0 || period_start !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_ps_clear: got %0h/%0b expected 0/0", out, period_start);
    end
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_freq();
    test_tri_switch();
    test_square();
    test_noise();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
